// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle joining the pipeline fetch/data ports, the arbiter and the shared memory.
interface mem_port_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        stall_if;
   logic        stall_mem;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        bus_err;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, stall_if, stall_mem,
             mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, stall_if, stall_mem,
             mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and data ports of the pipeline,
// data first with a bounded fetch starvation, and aborts memory accesses that never answer.
module mem_port_arbiter #(
   parameter int MAX_DATA_BURST = 4,
   parameter int TIMEOUT        = 64
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam int SC_W = $clog2(MAX_DATA_BURST + 1);
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SC_W-1:0] SC_MAX  = SC_W'(MAX_DATA_BURST);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] { IDLE, BUSY, RESP } state_t;

   state_t          state;
   logic            owner_data;
   logic [SC_W-1:0] starve_cnt;
   logic [TO_W-1:0] to_cnt;
   logic            i_ack_q;
   logic            d_ack_q;
   logic            mem_req_q;
   logic            mem_we_q;
   logic            bus_err_q;
   logic [31:0]     i_rdata_q;
   logic [31:0]     d_rdata_q;
   logic [31:0]     mem_addr_q;
   logic [31:0]     mem_wdata_q;
   logic            grant_data;
   logic            timed_out;
   logic [31:0]     resp_data;

   // A ready arriving in the final timeout cycle still counts as a normal completion.
   always_comb begin
      grant_data = bus.d_req & (~bus.i_req | (starve_cnt != SC_MAX));
      timed_out  = ~bus.mem_ready & (to_cnt == TO_LAST);
      resp_data  = (bus.mem_ready & ~mem_we_q) ? bus.mem_rdata : 32'h0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         owner_data  <= 1'b0;
         starve_cnt  <= '0;
         to_cnt      <= '0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         bus_err_q   <= 1'b0;
         i_rdata_q   <= 32'h0;
         d_rdata_q   <= 32'h0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
      end else begin
         i_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_req | bus.d_req) begin
                  owner_data  <= grant_data;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= grant_data & bus.d_we;
                  mem_addr_q  <= grant_data ? bus.d_addr : bus.i_addr;
                  mem_wdata_q <= grant_data ? bus.d_wdata : 32'h0;
                  to_cnt      <= '0;
                  state       <= BUSY;
                  if (!grant_data) begin
                     starve_cnt <= '0;
                  end else if (bus.i_req && (starve_cnt != SC_MAX)) begin
                     starve_cnt <= starve_cnt + SC_W'(1);
                  end
               end
            end
            BUSY: begin
               if (bus.mem_ready | timed_out) begin
                  mem_req_q <= 1'b0;
                  state     <= RESP;
                  if (owner_data) begin
                     d_rdata_q <= resp_data;
                     d_ack_q   <= 1'b1;
                  end else begin
                     i_rdata_q <= resp_data;
                     i_ack_q   <= 1'b1;
                  end
                  if (timed_out) begin
                     bus_err_q <= 1'b1;
                  end
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.i_ack     = i_ack_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.bus_err   = bus_err_q;
   assign bus.stall_if  = bus.i_req & ~i_ack_q;
   assign bus.stall_mem = bus.d_req & ~d_ack_q;
endmodule
